// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Holds the FSM state encoding and parity-mode selectors.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // xor_all is the XOR of every data bit and the received parity bit.
    function automatic logic parity_error(input logic xor_all, input int mode);
        if (mode == PARITY_ODD)
            return ~xor_all;
        else if (mode == PARITY_EVEN)
            return xor_all;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Frame delivery bus: data plus parity status, valid/ready handshake.
// master = receiver side, slave = consumer side.
interface serial_frame_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic                  PARITY_ERROR;

    modport master (
        output DATA_OUT,
        output DATA_VALID,
        output PARITY_ERROR,
        input  DATA_READY
    );

    modport slave (
        input  DATA_OUT,
        input  DATA_VALID,
        input  PARITY_ERROR,
        output DATA_READY
    );
endinterface

// File: rtl/sync_debounce.sv
// Purpose: 2-flop synchronizer followed by a stable-count debouncer, idle high.
// Latency: 2 cycles sync + DEBOUNCE_CYCLES cycles of stable input before dout moves.
// Backpressure: none; free-running.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            // Any cycle agreeing with dout restarts the stability window.
            if (sync[1] != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/serial_frame_receiver.sv
// Purpose: receive start/data/parity/stop frames clocked by an external serial clock.
// Latency: frame presented one cycle after the debounced stop-bit clock fall.
// Backpressure: one-entry holding register; a frame completing while full is dropped and OVERRUN set.
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PARITY_MODE     = 1,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input  logic                    FAST_CLOCK,
    input  logic                    RESET_N,
    input  logic                    SERIAL_CLOCK,
    input  logic                    SERIAL_DATA,
    serial_frame_receiver_if.master frame,
    output logic                    FRAME_ERROR,
    output logic                    OVERRUN
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

    logic clk_db, data_db, clk_db_q;
    logic strobe, commit, handshake;

    state_t                state;
    logic [BW-1:0]         bit_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_q;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clk_db (
        .clk(FAST_CLOCK), .rst_n(RESET_N), .din(SERIAL_CLOCK), .dout(clk_db)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_data_db (
        .clk(FAST_CLOCK), .rst_n(RESET_N), .din(SERIAL_DATA), .dout(data_db)
    );

    always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
        if (!RESET_N) clk_db_q <= 1'b1;
        else          clk_db_q <= clk_db;
    end

    assign strobe    = clk_db_q & ~clk_db;
    assign commit    = (state == ST_STOP) && strobe && data_db;
    assign handshake = frame.DATA_VALID && frame.DATA_READY;

    always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            shreg       <= '0;
            perr_q      <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            FRAME_ERROR <= 1'b0;
            if (state == ST_IDLE) begin
                tmo_cnt <= '0;
                if (strobe) begin
                    if (!data_db) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end else begin
                        FRAME_ERROR <= 1'b1;
                    end
                end
            end else if (strobe) begin
                tmo_cnt <= '0;
                case (state)
                    ST_DATA: begin
                        shreg <= {data_db, shreg[DATA_WIDTH-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        perr_q <= parity_error(^shreg ^ data_db, PARITY_MODE);
                        state  <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!data_db) FRAME_ERROR <= 1'b1;
                    end
                endcase
            end else if (tmo_cnt == TMO_MAX) begin
                // Serial clock stalled mid-frame: abandon the partial frame.
                state       <= ST_IDLE;
                tmo_cnt     <= '0;
                FRAME_ERROR <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge FAST_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame.DATA_OUT     <= '0;
            frame.DATA_VALID   <= 1'b0;
            frame.PARITY_ERROR <= 1'b0;
            OVERRUN            <= 1'b0;
        end else begin
            // A commit coinciding with a handshake replaces the frame and leaves OVERRUN alone.
            if (commit && (!frame.DATA_VALID || handshake)) begin
                frame.DATA_OUT     <= shreg;
                frame.PARITY_ERROR <= perr_q;
                frame.DATA_VALID   <= 1'b1;
            end else if (handshake) begin
                frame.DATA_VALID <= 1'b0;
                OVERRUN          <= 1'b0;
            end
            if (commit && frame.DATA_VALID && !frame.DATA_READY)
                OVERRUN <= 1'b1;
        end
    end
endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (range 5..16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable FAST_CLOCK cycles needed to accept a line change (minimum 2).
REQ-003 SHALL have parameter PARITY_MODE, default 1, parity scheme: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum FAST_CLOCK cycles allowed between serial-clock falling edges inside a frame.
REQ-005 SHALL have port FAST_CLOCK  in  1  sole system clock; all flops clock on its rising edge.
REQ-006 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port SERIAL_CLOCK  in  1  external serial clock, asynchronous, idle high.
REQ-008 SHALL have port SERIAL_DATA  in  1  external serial data, asynchronous, idle high.
REQ-009 SHALL have port DATA_READY  in  1  consumer accepts the frame when DATA_VALID and DATA_READY are both high.
REQ-010 SHALL have port DATA_OUT  out  DATA_WIDTH  received data bits, LSB received first.
REQ-011 SHALL have port DATA_VALID  out  1  DATA_OUT holds an unconsumed frame.
REQ-012 SHALL have port PARITY_ERROR  out  1  parity mismatch status of the frame on DATA_OUT, valid only while DATA_VALID is high.
REQ-013 SHALL have port FRAME_ERROR  out  1  single-cycle pulse when a frame is dropped.
REQ-014 SHALL have port OVERRUN  out  1  sticky flag: a completed frame was lost while DATA_VALID was high.

Function
REQ-015 Each serial input SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-016 Debounced output SHALL change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion before that SHALL clear the count.
REQ-017 A falling edge of the debounced clock SHALL produce a one-cycle strobe; debounced data SHALL be sampled in that cycle.
REQ-018 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: strobe with data 0 SHALL go to DATA with bit count 0; strobe with data 1 SHALL stay in IDLE and pulse FRAME_ERROR.
REQ-020 DATA: each strobe SHALL shift in one bit, LSB first; after DATA_WIDTH bits the FSM SHALL go to PARITY, or to STOP when PARITY_MODE = 0.
REQ-021 PARITY: the strobe SHALL capture the parity bit.
REQ-022 PARITY_ERROR SHALL be set when the XOR of the data bits and the parity bit is 0 (odd mode) or 1 (even mode).
REQ-023 STOP: a strobe with data 1 SHALL commit the frame and return to IDLE; a strobe with data 0 SHALL drop the frame, pulse FRAME_ERROR and return to IDLE.
REQ-024 Commit SHALL load DATA_OUT and PARITY_ERROR and raise DATA_VALID in the cycle after the stop-bit strobe.
REQ-025 A frame with a parity error SHALL still be delivered, with PARITY_ERROR = 1.
REQ-026 DATA_VALID, DATA_OUT and PARITY_ERROR SHALL hold until the handshake; DATA_VALID SHALL fall in the cycle after the handshake.
REQ-027 A commit while DATA_VALID = 1 and DATA_READY = 0 SHALL discard the new frame, keep the old frame, and set OVERRUN.
REQ-028 A commit in the same cycle as a handshake SHALL load the new frame, keep DATA_VALID high, and leave OVERRUN unchanged.
REQ-029 OVERRUN SHALL clear on the next handshake.
REQ-030 The timeout counter SHALL run in every non-IDLE state and reset on each strobe.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, discard the partial frame, and pulse FRAME_ERROR.
REQ-032 Counter widths SHALL be $clog2 of their maximum count, with no wrap-around.

Reset
REQ-033 While RESET_N = 0: FSM in IDLE; counters 0; synchronizer and debounced values 1.
REQ-034 While RESET_N = 0: DATA_OUT 0; DATA_VALID, PARITY_ERROR, FRAME_ERROR and OVERRUN all 0.
REQ-035 Reset mid-frame SHALL abandon the frame without any FRAME_ERROR pulse.

Structure
REQ-036 Package serial_frame_pkg SHALL hold the FSM state enum and the PARITY_NONE/ODD/EVEN constants.
REQ-037 Sub-module sync_debounce (synchronizer plus debouncer, parameter DEBOUNCE_CYCLES) SHALL be instantiated once for SERIAL_CLOCK and once for SERIAL_DATA.

Verification
REQ-038 Frame 0x1C, odd parity bit 0, stop 1, DATA_READY = 1 -> DATA_OUT = 0x1C, DATA_VALID high for 1 cycle, PARITY_ERROR = 0.
REQ-039 Same frame with parity bit 1 -> DATA_OUT = 0x1C, PARITY_ERROR = 1.
REQ-040 10-cycle glitch on SERIAL_CLOCK with DEBOUNCE_CYCLES = 16 -> no strobe, FSM stays IDLE.
REQ-041 Frame 0x5A with stop bit 0 -> FRAME_ERROR single pulse, DATA_VALID stays 0.
REQ-042 4 data bits then clock idle for 50000 cycles -> FRAME_ERROR pulse, FSM IDLE; next full frame 0x33 received correctly.
REQ-043 DATA_READY = 0, frames 0x11 then 0x22 -> DATA_OUT = 0x11, OVERRUN = 1; DATA_READY pulsed -> OVERRUN = 0, DATA_VALID = 0.
